// File: rtl/mdom_trigger_mc.sv
// Multi-channel mDOM waveform trigger: stream pass-through, ToT filter, holdoff.
// Optional trig/drop counters when MDOM_TRIG_COUNTERS_EN is defined.
module mdom_trigger_mc #(
  parameter int N_CH      = 2,
  parameter int ADC_W     = 12,
  parameter int DISCR_W   = 8,
  parameter int HOLDOFF_W = 16,
  parameter int TOT_W     = 8,
  parameter int CH_IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*ADC_W-1:0]     adc_stream_in,
  output logic [N_CH*ADC_W-1:0]     adc_stream_out,
  input  logic [N_CH*DISCR_W-1:0]   discr_stream_in,
  output logic [N_CH*DISCR_W-1:0]   discr_stream_out,
  input  logic [N_CH-1:0]           chan_en,
  input  logic                      gt,
  input  logic                      et,
  input  logic                      lt,
  input  logic [ADC_W-1:0]          thr,
  input  logic [TOT_W-1:0]          tot_min,
  input  logic                      thresh_trig_en,
  input  logic                      discr_trig_en,
  input  logic                      discr_trig_pol,
  input  logic                      run,
  input  logic                      ext_trig_en,
  input  logic                      ext_run,
  input  logic [HOLDOFF_W-1:0]      holdoff,
  output logic                      trig,
  output logic [1:0]                trig_src,
  output logic [CH_IDX_W-1:0]       trig_chan,
  output logic [N_CH-1:0]           thresh_tot,
  output logic [N_CH-1:0]           discr_tot,
`ifdef MDOM_TRIG_COUNTERS_EN
  input  logic                      cnt_clr,
  output logic [31:0]               trig_count,
  output logic [31:0]               drop_count,
`endif
  output logic                      armed
);

  localparam logic [0:0] ST_ARMED = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic [1:0] SRC_SW     = 2'd0;
  localparam logic [1:0] SRC_THRESH = 2'd1;
  localparam logic [1:0] SRC_EXT    = 2'd2;
  localparam logic [1:0] SRC_DISCR  = 2'd3;

  logic [N_CH-1:0]      cmp;
  logic [N_CH-1:0]      draw;
  logic [N_CH-1:0]      qual;
  logic [TOT_W-1:0]     tot_eff;

  logic                 run_q;
  logic                 ext_q;
  logic                 run_p;
  logic                 ext_p;

  logic                 c_ext;
  logic                 c_discr;
  logic                 c_thr;
  logic                 c_sw;
  logic                 any_c;

  logic [1:0]           sel_src;
  logic [CH_IDX_W-1:0]  sel_chan;

  logic [0:0]           state;
  logic [0:0]           state_nx;
  logic [HOLDOFF_W-1:0] hcnt;
  logic [HOLDOFF_W-1:0] hcnt_nx;
  logic                 accept;

  // tot_min of zero means qualify on the first over-threshold sample
  assign tot_eff = (tot_min == '0) ? TOT_W'(1) : tot_min;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [ADC_W-1:0]   a;
    logic [DISCR_W-1:0] d;
    logic [TOT_W-1:0]   run_len;
    logic [TOT_W:0]     inc;

    assign a = adc_stream_in[k*ADC_W +: ADC_W];
    assign d = discr_stream_in[k*DISCR_W +: DISCR_W];

    assign cmp[k] = (gt & (a > thr))
                  | (et & (a == thr))
                  | (lt & (a < thr));

    assign draw[k] = discr_trig_pol ? (|d) : ~(&d);

    assign inc     = {1'b0, run_len} + (TOT_W+1)'(1);
    assign qual[k] = cmp[k] & (inc >= {1'b0, tot_eff});

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        run_len <= '0;
      end else if (!cmp[k]) begin
        run_len <= '0;
      end else if (qual[k]) begin
        run_len <= tot_eff;
      end else begin
        run_len <= inc[TOT_W-1:0];
      end
    end
  end

  function automatic logic [CH_IDX_W-1:0] lowest(
    input logic [N_CH-1:0] v
  );
    logic [CH_IDX_W-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) r = CH_IDX_W'(i);
    end
    return r;
  endfunction

  assign run_p = run & ~run_q;
  assign ext_p = ext_run & ~ext_q;

  assign c_ext   = ext_trig_en & ext_p;
  assign c_discr = discr_trig_en & (|(draw & chan_en));
  assign c_thr   = thresh_trig_en & (|(qual & chan_en));
  assign c_sw    = run_p;
  assign any_c   = c_ext | c_discr | c_thr | c_sw;

  always_comb begin
    sel_src  = SRC_SW;
    sel_chan = '0;
    if (c_ext) begin
      sel_src = SRC_EXT;
    end else if (c_discr) begin
      sel_src  = SRC_DISCR;
      sel_chan = lowest(draw & chan_en);
    end else if (c_thr) begin
      sel_src  = SRC_THRESH;
      sel_chan = lowest(qual & chan_en);
    end
  end

  // Holdoff of N gives N dead cycles: count N..1, rearm on 1
  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    accept   = 1'b0;
    case (state)
      ST_ARMED: begin
        if (any_c) begin
          accept = 1'b1;
          if (holdoff != '0) begin
            state_nx = ST_HOLD;
            hcnt_nx  = holdoff;
          end
        end
      end
      ST_HOLD: begin
        if (hcnt <= HOLDOFF_W'(1)) begin
          state_nx = ST_ARMED;
          hcnt_nx  = '0;
        end else begin
          hcnt_nx = hcnt - HOLDOFF_W'(1);
        end
      end
      default: begin
        state_nx = ST_ARMED;
        hcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_stream_out   <= '0;
      discr_stream_out <= '0;
      thresh_tot       <= '0;
      discr_tot        <= '0;
      run_q            <= 1'b0;
      ext_q            <= 1'b0;
      state            <= ST_ARMED;
      hcnt             <= '0;
      trig             <= 1'b0;
      trig_src         <= '0;
      trig_chan        <= '0;
      armed            <= 1'b0;
    end else begin
      adc_stream_out   <= adc_stream_in;
      discr_stream_out <= discr_stream_in;
      thresh_tot       <= cmp;
      discr_tot        <= draw;
      run_q            <= run;
      ext_q            <= ext_run;
      state            <= state_nx;
      hcnt             <= hcnt_nx;
      trig             <= accept;
      trig_src         <= accept ? sel_src : 2'd0;
      trig_chan        <= accept ? sel_chan : '0;
      armed            <= (state_nx == ST_ARMED);
    end
  end

`ifdef MDOM_TRIG_COUNTERS_EN
  logic drop;

  assign drop = (state == ST_HOLD) & any_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_count <= '0;
      drop_count <= '0;
    end else if (cnt_clr) begin
      trig_count <= '0;
      drop_count <= '0;
    end else begin
      if (accept) trig_count <= trig_count + 32'd1;
      if (drop)   drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mdom_trigger_mc.md
Name: mdom_trigger_mc

Overview:
Multi-channel successor to the single-channel mDOM waveform trigger. It takes N_CH parallel ADC and discriminator streams and registers them through unchanged. It arbitrates external, discriminator, threshold and software triggers. It adds a minimum time-over-threshold filter and a programmable post-trigger holdoff, and sits between the ADC deserialisers and the waveform buffer writer.

Parameters:
N_CH, 2, number of channels
ADC_W, 12, ADC sample width per channel
DISCR_W, 8, discriminator sub-samples per channel per clock
HOLDOFF_W, 16, width of holdoff counter
TOT_W, 8, width of min-ToT setting
CH_IDX_W, max(1,clog2(N_CH)), width of trig_chan

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
adc_stream_in  in  N_CH*ADC_W  ch k at bits [k*ADC_W +: ADC_W]
adc_stream_out  out  N_CH*ADC_W  registered copy
discr_stream_in  in  N_CH*DISCR_W  same packing
discr_stream_out  out  N_CH*DISCR_W  registered copy
chan_en  in  N_CH  per-channel mask for threshold and discr triggers
gt, et, lt  in  1 each  comparator mode
thr  in  ADC_W  threshold, unsigned
tot_min  in  TOT_W  required consecutive over-threshold cycles
thresh_trig_en  in  1  threshold trigger enable
discr_trig_en  in  1  discr trigger enable
discr_trig_pol  in  1  0: any sub-sample low; 1: any high
run  in  1  software trigger, rising edge
ext_trig_en  in  1  external trigger enable
ext_run  in  1  external trigger, rising edge
holdoff  in  HOLDOFF_W  dead cycles after each trigger
trig  out  1  one-cycle trigger, aligned with stream outputs
trig_src  out  2  0 SW, 1 THRESH, 2 EXT, 3 DISCR; 0 when trig=0
trig_chan  out  CH_IDX_W  lowest channel causing THRESH/DISCR trigger, else 0
thresh_tot  out  N_CH  registered raw comparator result per channel
discr_tot  out  N_CH  registered raw discr result per channel
armed  out  1  1 in ARMED state

Behaviour:
- Reset: all outputs 0. State is ARMED internally, but the armed output reads 0 during reset and 1 from the first clock after release. The edge-detector history registers and all counters are 0.
- Latency: streams, thresh_tot, discr_tot, trig, trig_src and trig_chan are all registered with 1 cycle of latency from input.
- Comparator per channel: cmp = (gt & a>thr) | (et & a==thr) | (lt & a<thr), unsigned.
- Discr per channel: pol0 → ~&bits; pol1 → |bits.
- Edge detect: run_p = run & ~run_q. ext_run likewise. History resets to 0, so an input that is high at reset release yields an edge on the first cycle.
- ToT filter: each channel has a run-length counter. It increments while cmp=1, saturates at max(tot_min,1), and clears to 0 when cmp=0. The channel qualifies while cmp=1 and counter+1 >= max(tot_min,1). tot_min=0 behaves as 1, i.e. immediate.
- Candidates:
  - ext = ext_trig_en & ext_run_p
  - discr = discr_trig_en & |(discr_raw & chan_en)
  - thresh = thresh_trig_en & |(qual & chan_en)
  - sw = run_p
- Priority: ext > discr > thresh > sw. trig_chan is the lowest-index contributing channel of the winning source.
- FSM:
  - ARMED: on any candidate → trig=1, src/chan loaded. If holdoff≠0, load cnt=holdoff and go to HOLDOFF. Otherwise stay ARMED, so triggers may occur on consecutive cycles.
  - HOLDOFF: trig=0 and cnt decrements. When cnt reaches 1, return to ARMED. This gives exactly `holdoff` dead cycles after the trigger cycle.
- Candidates during HOLDOFF are dropped, not queued. ToT counters and edge history keep running during HOLDOFF.
- Changing holdoff mid-HOLDOFF does not affect the current countdown.
- Async reset mid-HOLDOFF returns to ARMED with the count cleared.

Optional Feature:
MDOM_TRIG_COUNTERS_EN:
- Defined: adds outputs trig_count[31:0] (accepted triggers) and drop_count[31:0] (candidates discarded in HOLDOFF), plus input cnt_clr, which synchronously zeroes both. Both counters wrap at 2^32 and reset to 0.
- Undefined: these ports and this logic are absent.

Test Plan:
- N_CH=2, gt=1, thr=100, tot_min=3, ch1 samples 101,101,101 → trig=1, src=1, chan=1, one cycle after the 3rd sample. A run of only 2 samples gives no trig.
- holdoff=4, ch0 held over thr with tot_min=0 → trig pulses on cycles 1, 6, 11, with exactly 4 zero cycles between pulses.
- Same cycle: ext_run rise, discr pol1 ch0 bit set, ch1 over threshold, run rise → src=2 (EXT), chan=0. Next candidate after holdoff=0 resolves to the remaining sources by priority.
- chan_en=2'b01, discr pol0, ch1 bits 8'hFE, ch0 8'hFF → no trig. Then ch0 8'h7F → trig src=3, chan=0.
- run rises during HOLDOFF → no trig, and drop_count increments when the macro is defined. Assert rst mid-HOLDOFF → all outputs 0 immediately. After release, armed=1 and the next thr crossing triggers.
